// File: rtl/xuart_tx.sv
// xuart_tx: memory-mapped 8N1 UART transmitter on the xctrl data-memory bus.
// Registers (word offsets from BASE): 0 TXDATA (wo), 1 STATUS (ro), 2 DIV (rw), 3 reserved.
// Read data is combinational in the access cycle; writes land on the closing clk edge.
// Build option: define XUART_TX_FIFO_EN for a 4-entry transmit FIFO; otherwise a
// single holding register (depth 1) buffers the next byte.
module xuart_tx #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = ADDR_W'('h100),
    parameter logic [15:0]       DIV_RST = 16'd433
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              tx
);

`ifdef XUART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bus decode
    logic       hit;
    logic [1:0] off;
    logic       wr_txdata;
    logic       wr_div;
    logic       rd_status;

    // Buffer state
    logic [7:0]       mem [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       count;
    logic             overflow;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic             push_drop;

    // Transmitter state
    state_t      state;
    logic [15:0] div_q;
    logic [15:0] bit_cnt;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        busy;

    // Write data above the DIV field is never stored anywhere.
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[DATA_W-1:16];

    assign hit       = sel && (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign off       = addr[1:0];
    assign wr_txdata = hit && we && (off == 2'd0);
    assign wr_div    = hit && we && (off == 2'd2);
    assign rd_status = hit && !we && (off == 2'd1);

    assign full  = (count == DEPTH_C);
    assign empty = (count == 3'd0);
    assign busy  = (state != IDLE);

    // The transmitter takes a byte whenever it is idle and one is waiting. A push
    // that coincides with a pop always fits, even when the buffer is full.
    assign pop       = (state == IDLE) && !empty;
    assign push_ok   = wr_txdata && (!full || pop);
    assign push_drop = wr_txdata && full && !pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (DEPTH == 1 || p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Buffer storage: written on accepted pushes only.
    // NOTE: the data array has no reset; occupancy is tracked by count/pointers,
    // so stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    // Buffer pointers and occupancy count.
    // NOTE: every state flop uses an asynchronous reset so the line and the
    // buffer clear immediately on rst, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag: a dropped push sets it, a STATUS read clears it,
    // and a set in the same cycle as the clearing read takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (rd_status) begin
            overflow <= 1'b0;
        end
    end

    // Baud divider register; only sampled at bit boundaries by the transmitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_RST;
        end else if (wr_div) begin
            div_q <= data_in[15:0];
        end
    end

    // 8N1 frame sequencer with a registered line output. Each bit lasts div_q+1
    // cycles: the down-counter is reloaded at every bit start and the bit ends
    // on the cycle it reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= 8'h00;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= div_q;
                        bit_idx <= 3'd0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= div_q;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= div_q;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux: zero unless this block is read this cycle.
    // NOTE: data_out gets a default before any branch so no latch is inferred.
    always_comb begin
        data_out = '0;
        if (hit && !we) begin
            case (off)
                2'd1:    data_out[6:0]  = {count, overflow, empty, full, busy};
                2'd2:    data_out[15:0] = div_q;
                default: data_out       = '0;
            endcase
        end
    end

endmodule

// File: doc/xuart_tx.md
# xuart_tx

Memory-mapped UART transmitter that is the responder on the processor data-memory bus driven by `xctrl`. It decodes `sel`/`we`/`addr` and returns read data combinationally in the same cycle, because the controller consumes read data in the cycle it issues the access. Words written to its data register are queued and shifted out serially as 8N1 frames on `tx`. Status and baud-divider registers are visible on the same bus.

## Interface
- `BASE`, default `ADDR_W'h100`: block base address. Bits `[1:0]` must be zero; the block occupies `BASE..BASE+3`.
- `DIV_RST`, default `16'd433`: reset value of the divider register. Bit period is `DIV+1` clk cycles.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel`  in  1  bus access strobe (`data_mem_sel`).
- `we`  in  1  write enable (`data_mem_we`), valid with `sel`.
- `addr`  in  `ADDR_W`  word address (`data_mem_addr`).
- `data_in`  in  `DATA_W`  write data (`data_to_mem`).
- `data_out`  out  `DATA_W`  read data (to `data_from_mem`). Combinational; 0 when not selected.
- `tx`  out  1  serial output, idle high.

## Operation
- Decode: `hit = sel && addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]`; `off = addr[1:0]`.
- Register map:
  - off 0, TXDATA, write-only, reads 0. A write pushes `data_in[7:0]` into the FIFO.
  - off 1, STATUS, read-only:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[6:4] FIFO count
    - other bits 0
  - off 2, DIV, read/write, bits [15:0]; upper read bits 0.
  - off 3: reads 0, writes ignored.
- `data_out` is the register selected by `off` when `hit && !we`, otherwise 0.
- FIFO behaviour:
  - A push when full is dropped and sets overflow.
  - A read of STATUS (`hit && !we && off==1`) clears overflow at the clock edge ending that access. If an overflow occurs in that same cycle, the set wins.
  - Push and pop in the same cycle are both performed, including when full: the slot frees and the push is accepted.
- FSM, 8N1, LSB first:
  - IDLE: `tx=1`. If the FIFO is non-empty, pop into the shift register, load the bit counter with DIV, and go to START.
  - START: `tx=0` for one bit period, then go to DATA.
  - DATA: `tx=shift[0]`; shift right each bit period. After 8 bits go to STOP.
  - STOP: `tx=1` for one bit period. Then go to IDLE; IDLE pops again on the next cycle if data remains.
- Bit timing: a down-counter is loaded from DIV at each bit start; the bit ends when the counter reaches 0. A DIV write during a frame takes effect from the next bit boundary.
- `tx` is registered (driven from a flop).

## Timing
- Reset values:
  - `tx=1`, `data_out=0` (nothing selected)
  - FIFO empty, count 0, overflow 0
  - FSM IDLE, DIV=`DIV_RST`, shift register 0
- Read latency: 0 cycles (combinational from `sel`/`addr`).
- Write latency: the register updates at the clk edge ending the access.
- TXDATA write to idle block, accepted at edge N:
  - IDLE sees non-empty at edge N+1 → START.
  - `tx` falls after edge N+1.
  - Busy reads 1 from cycle N+1.
- Frame length: `10*(DIV+1)` cycles from start-bit fall to end of stop bit. Back-to-back frames add exactly 1 IDLE cycle.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously), FIFO and FSM are cleared, and the partial frame is lost.
- Count wrap: pointers wrap modulo depth. Count saturates at depth via full; there is no wrap aliasing.

## Configuration
- `XUART_TX_FIFO_EN` defined:
  - 4-entry FIFO.
  - full at count 4.
  - count field holds 0..4.
- Undefined:
  - FIFO replaced by a single holding register (depth 1).
  - full = holding register occupied; count is 0/1.
  - Overflow and all other behaviour are identical.

## Test plan
- Reset with `DIV_RST=3`: `tx=1`; STATUS reads `0x4`; DIV reads 3.
- DIV=3, write TXDATA `0xA5` → `tx` pattern, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1. STATUS busy=1 during the frame, 0 one cycle after the stop bit ends.
- With FIFO_EN, write 5 bytes in consecutive cycles while a frame is in progress → 4 frames transmitted, overflow=1. A STATUS read returns bit3=1; the next STATUS read returns bit3=0.
- Write DIV=1 in the middle of the DATA state at DIV=3 → the current bit keeps 4 cycles; subsequent bits take 2 cycles.
- Assert `rst` during bit 4 of a frame → `tx=1` the same cycle; after release STATUS reads `0x4` and no frame resumes.
- Read off 0 / off 3, a miss address (`BASE+4`), and `sel=0` → `data_out=0` in every case.
